// File: rtl/bram_req_pkg.sv
// bram_req_pkg: shared latency helper and RESP_DEPTH legality check for the BRAM requester.
package bram_req_pkg;
  function automatic int bram_lat(input bit pipelined);
    return pipelined ? 2 : 1;
  endfunction
  function automatic bit resp_depth_ok(input int depth, input int lat);
    return depth >= lat + 1 && (depth & (depth - 1)) == 0;
  endfunction
endpackage

// File: rtl/bram_resp_fifo.sv
// bram_resp_fifo: first-word fall-through response FIFO with occupancy count.
module bram_resp_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 32,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  assign head = mem[rptr];
  always_ff @(posedge clk)
    if (push) mem[wptr] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: rtl/bram_req_ctrl.sv
// bram_req_ctrl: valid/ready to BRAM port strobes with credit-tracked read responses.
// Optional BRAM_REQ_WRITE_ACK_EN: writes also return one response (write-first DOx).
module bram_req_ctrl
  import bram_req_pkg::*;
#(
  parameter int PIPELINED = 0,
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32,
  parameter int RESP_DEPTH = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_data,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  busy,
  output logic                  bram_en,
  output logic                  bram_we,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_din,
  input  logic [DATA_WIDTH-1:0] bram_dout
);
  localparam int LAT = bram_lat(PIPELINED != 0);
  localparam int CW = $clog2(RESP_DEPTH) + 1;
  if (!resp_depth_ok(RESP_DEPTH, LAT)) begin : g_bad_depth
    $error("RESP_DEPTH must be a power of 2 and at least LAT+1");
  end
  logic [CW-1:0] count, f_cnt;
  logic [LAT-1:0] pipe;
  logic [DATA_WIDTH-1:0] head;
  logic fire, need, cap, pop, f_empty, f_push, f_pop;
`ifdef BRAM_REQ_WRITE_ACK_EN
  assign need = 1'b1;
`else
  assign need = !req_write;
`endif
  assign req_ready = !RST && count < CW'(RESP_DEPTH);
  assign fire = req_valid && req_ready;
  assign bram_en = fire;
  assign bram_we = fire && req_write;
  assign bram_addr = req_addr;
  assign bram_din = req_data;
  assign cap = pipe[LAT-1];
  assign f_empty = f_cnt == '0;
  // Empty FIFO bypass: data arriving on DOx is presented in the same cycle it appears.
  assign resp_valid = !RST && (!f_empty || cap);
  assign resp_data = f_empty ? bram_dout : head;
  assign pop = resp_valid && resp_ready;
  assign f_pop = pop && !f_empty;
  assign f_push = cap && !RST && !(f_empty && pop);
  assign busy = !RST && count != '0;
  always_ff @(posedge CLK) begin
    if (RST) begin
      count <= '0;
      pipe <= '0;
    end else begin
      count <= count + CW'(fire && need) - CW'(pop);
      pipe[0] <= fire && need;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  bram_resp_fifo #(.DEPTH(RESP_DEPTH), .W(DATA_WIDTH)) u_fifo (
    .clk(CLK),
    .rst(RST),
    .push(f_push),
    .pop(f_pop),
    .din(bram_dout),
    .head(head),
    .count(f_cnt)
  );
endmodule

// File: tb/tb_bram_req_ctrl.sv
// tb_bram_req_ctrl: two controllers (PIPELINED 0 and 1) on shared stimulus, each against a queue model.
module tb_bram_req_ctrl;
  localparam int AW = 9, DW = 32, D = 4;
`ifdef BRAM_REQ_WRITE_ACK_EN
  localparam bit ACK = 1'b1;
`else
  localparam bit ACK = 1'b0;
`endif
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, rv, rw, rr;
  logic [AW-1:0] ra;
  logic [DW-1:0] rd;
  logic rdy[2], rsv[2], bsy[2], en[2], we[2];
  logic [AW-1:0] ba[2];
  logic [DW-1:0] bd[2], rdat[2], dout[2], dq1[2], dq2;
  logic [DW-1:0] bm[2][512];
  bit wr[2][512];
  logic [DW-1:0] rm[2][512];
  logic [DW-1:0] qd[2][$];
  int unsigned qt[2][$];
  int unsigned cyc_n;
  int n, nf, k;
  bit last_fire[2];
  function automatic logic [31:0] init_word(input int a);
    return a == 5 ? 32'hDEADBEEF : (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction
  // Write-first BRAM behaviour; port 1 adds an output register stage.
  always @(posedge clk)
    for (int i = 0; i < 2; i++)
      if (en[i]) begin
        if (we[i]) begin
          bm[i][ba[i]] <= bd[i];
          wr[i][ba[i]] <= 1'b1;
          dq1[i] <= bd[i];
        end else dq1[i] <= wr[i][ba[i]] ? bm[i][ba[i]] : init_word(int'(ba[i]));
      end
  always @(posedge clk) dq2 <= dq1[1];
  assign dout[0] = dq1[0];
  assign dout[1] = dq2;
  bram_req_ctrl #(.PIPELINED(0), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESP_DEPTH(D)) u0 (
    .CLK(clk), .RST(rst), .req_valid(rv), .req_ready(rdy[0]), .req_write(rw), .req_addr(ra),
    .req_data(rd), .resp_valid(rsv[0]), .resp_ready(rr), .resp_data(rdat[0]), .busy(bsy[0]),
    .bram_en(en[0]), .bram_we(we[0]), .bram_addr(ba[0]), .bram_din(bd[0]), .bram_dout(dout[0]));
  bram_req_ctrl #(.PIPELINED(1), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESP_DEPTH(D)) u1 (
    .CLK(clk), .RST(rst), .req_valid(rv), .req_ready(rdy[1]), .req_write(rw), .req_addr(ra),
    .req_data(rd), .resp_valid(rsv[1]), .resp_ready(rr), .resp_data(rdat[1]), .busy(bsy[1]),
    .bram_en(en[1]), .bram_we(we[1]), .bram_addr(ba[1]), .bram_din(bd[1]), .bram_dout(dout[1]));
  task automatic chk(input string tag, input int i, input logic [63:0] obs, input logic [63:0] exp);
    n++;
    assert (obs === exp) else begin
      nf++;
      $error("FAIL %s[%0d] cycle %0d observed=%0h expected=%0h", tag, i, cyc_n, obs, exp);
    end
  endtask
  task automatic step();
    bit er, ev, f;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      er = !rst && qd[i].size() < D;
      ev = !rst && qd[i].size() > 0 && qt[i][0] <= cyc_n;
      f = rv && er;
      chk("req_ready", i, 64'(rdy[i]), 64'(er));
      chk("bram_en", i, 64'(en[i]), 64'(f));
      chk("bram_we", i, 64'(we[i]), 64'(f && rw));
      chk("bram_addr", i, 64'(ba[i]), 64'(ra));
      chk("bram_din", i, 64'(bd[i]), 64'(rd));
      chk("resp_valid", i, 64'(rsv[i]), 64'(ev));
      if (ev) chk("resp_data", i, 64'(rdat[i]), 64'(qd[i][0]));
      chk("busy", i, 64'(bsy[i]), 64'(!rst && qd[i].size() != 0));
      if (rst) begin
        qd[i].delete();
        qt[i].delete();
      end else begin
        if (ev && rr) begin
          void'(qd[i].pop_front());
          void'(qt[i].pop_front());
        end
        if (f) begin
          if (rw) rm[i][ra] = rd;
          if (!rw || ACK) begin
            qd[i].push_back(rw ? rd : rm[i][ra]);
            qt[i].push_back(cyc_n + 32'(i) + 1);
          end
        end
      end
      last_fire[i] = f;
    end
    chk("push_into_full", 0, 64'(u0.f_push && u0.f_cnt == 3'(D)), 64'd0);
    chk("push_into_full", 1, 64'(u1.f_push && u1.f_cnt == 3'(D)), 64'd0);
    @(posedge clk);
    #1;
    cyc_n++;
  endtask
  initial begin
    n = 0; nf = 0; cyc_n = 0; k = 0;
    for (int i = 0; i < 2; i++)
      for (int a = 0; a < 512; a++) rm[i][a] = init_word(a);
    rst = 1'b1; rv = 1'b0; rw = 1'b0; ra = '0; rd = '0; rr = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    // single read of preloaded word
    rv = 1'b1; ra = 9'd5; step();
    rv = 1'b0; repeat (4) step();
    // write then read the same address
    rv = 1'b1; rw = 1'b1; ra = 9'd3; rd = 32'h12345678; step();
    rw = 1'b0; step();
    rv = 1'b0; repeat (4) step();
    // back-pressure: only four reads may be outstanding
    rr = 1'b0; k = 0;
    for (int c = 0; c < 10; c++) begin
      rv = k < 8; ra = 9'(k); step();
      if (last_fire[0]) k++;
    end
    chk("bp_fired", 0, 64'(k), 64'd4);
    rr = 1'b1;
    for (int c = 0; c < 40 && k < 8; c++) begin
      rv = 1'b1; ra = 9'(k); step();
      if (last_fire[0]) k++;
    end
    chk("bp_all_issued", 0, 64'(k), 64'd8);
    rv = 1'b0; repeat (6) step();
    // full: pop and offer together, read fires the following cycle
    rr = 1'b0; rv = 1'b1;
    for (int c = 0; c < 6; c++) begin ra = 9'(16 + c); step(); end
    rr = 1'b1; step();
    chk("full_pop_no_fire", 0, 64'(last_fire[0]), 64'd0);
    rr = 1'b0; ra = 9'd40; step();
    chk("fire_after_pop", 0, 64'(last_fire[0]), 64'd1);
    rr = 1'b1; rv = 1'b0; repeat (8) step();
    // reset with reads buffered and in flight
    rr = 1'b0; rv = 1'b1;
    for (int c = 0; c < 3; c++) begin ra = 9'(8 + c); step(); end
    rv = 1'b0; rst = 1'b1; step();
    rst = 1'b0; rr = 1'b1; repeat (4) step();
    rv = 1'b1; ra = 9'd5; step();
    rv = 1'b0; repeat (4) step();
`ifdef BRAM_REQ_WRITE_ACK_EN
    rv = 1'b1; ra = 9'd1; step();
    rw = 1'b1; ra = 9'd7; rd = 32'hA5A5A5A5; step();
    rw = 1'b0; step();
    ra = 9'd2; step();
    rv = 1'b0; repeat (5) step();
`endif
    for (int c = 0; c < 400; c++) begin
      rst = $urandom_range(0, 99) == 0;
      rv = $urandom_range(0, 3) != 0;
      rw = $urandom_range(0, 3) == 0;
      ra = 9'($urandom_range(0, 15));
      rd = $urandom;
      rr = $urandom_range(0, 9) < 7;
      step();
    end
    rst = 1'b0; rv = 1'b0; rw = 1'b0; rr = 1'b1;
    repeat (6) step();
    $display("== %0d vectors applied, %0d miscompares ==", n, nf);
    $finish;
  end
endmodule
